multi_cycle_controller: RTL and testbench

Sequencing controller for the multi-cycle variant of the lab MIPS core. It sits beside the shared datapath (single ALU, unified memory port, IR/ALUOut/A/B registers) and walks each instruction through fetch, decode, execute, memory and write-back states. Per state it issues the enables and mux selects that the single-cycle decoder issues once per instruction. It supports the same instruction subset: R-type ALU/shift, jr, jalr, lw, sw, lui, addi(u), andi, ori, slti(u), beq, bne, blez, bgtz, bltz, j, jal.

---
 rtl/mc_ctrl_pkg.sv | 101 ++++++++++
 rtl/inst_class_decoder.sv | 56 +++++
 rtl/multi_cycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// functs, datapath mux selects, ALUOp codes and the instruction class record.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] ASA_PC    = 2'b00;
    localparam logic [1:0] ASA_A     = 2'b01;
    localparam logic [1:0] ASA_SHAMT = 2'b10;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_MDR    = 2'b00;
    localparam logic [1:0] M2R_ALUOUT = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'ha;

    typedef struct packed {
        logic       rtype;
        logic       shift;
        logic       jump;
        logic       jreg;
        logic       link;
        logic       branch;
        logic       load;
        logic       store;
        logic       itype;
        logic       lui;
        logic       illegal;
        logic       ext_op;
        logic [3:0] alu_op;
    } inst_class_t;

endpackage

// File: rtl/inst_class_decoder.sv
// Combinational OpCode/Funct -> instruction class flags, ALUOp and ExtOp.
module inst_class_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  op_code_i,
    input  logic [5:0]  funct_i,
    output inst_class_t cls_o
);

    always_comb begin
        cls_o        = '0;
        cls_o.alu_op = ALU_ADD;
        case (op_code_i)
            OP_RTYPE: begin
                cls_o.rtype = 1'b1;
                case (funct_i)
                    F_SLL:  begin cls_o.shift = 1'b1; cls_o.alu_op = ALU_SLL; end
                    F_SRL:  begin cls_o.shift = 1'b1; cls_o.alu_op = ALU_SRL; end
                    F_SRA:  begin cls_o.shift = 1'b1; cls_o.alu_op = ALU_SRA; end
                    F_SLLV: cls_o.alu_op = ALU_SLL;
                    F_SRLV: cls_o.alu_op = ALU_SRL;
                    F_SRAV: cls_o.alu_op = ALU_SRA;
                    F_ADD, F_ADDU: cls_o.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: cls_o.alu_op = ALU_SUB;
                    F_AND:  cls_o.alu_op = ALU_AND;
                    F_OR:   cls_o.alu_op = ALU_OR;
                    F_XOR:  cls_o.alu_op = ALU_XOR;
                    F_NOR:  cls_o.alu_op = ALU_NOR;
                    F_SLT:  cls_o.alu_op = ALU_SLT;
                    F_SLTU: cls_o.alu_op = ALU_SLTU;
                    // Register jumps finish in ID and never reach EX/WB.
                    F_JR:   begin cls_o.rtype = 1'b0; cls_o.jreg = 1'b1; end
                    F_JALR: begin cls_o.rtype = 1'b0; cls_o.jreg = 1'b1; cls_o.link = 1'b1; end
                    default: begin cls_o.rtype = 1'b0; cls_o.illegal = 1'b1; end
                endcase
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                cls_o.branch = 1'b1;
                cls_o.ext_op = 1'b1;
                cls_o.alu_op = ALU_SUB;
            end
            OP_J:     cls_o.jump = 1'b1;
            OP_JAL:   begin cls_o.jump = 1'b1; cls_o.link = 1'b1; end
            OP_ADDI, OP_ADDIU: begin cls_o.itype = 1'b1; cls_o.ext_op = 1'b1; end
            OP_SLTI:  begin cls_o.itype = 1'b1; cls_o.ext_op = 1'b1; cls_o.alu_op = ALU_SLT; end
            OP_SLTIU: begin cls_o.itype = 1'b1; cls_o.ext_op = 1'b1; cls_o.alu_op = ALU_SLTU; end
            OP_ANDI:  begin cls_o.itype = 1'b1; cls_o.alu_op = ALU_AND; end
            OP_ORI:   begin cls_o.itype = 1'b1; cls_o.alu_op = ALU_OR; end
            OP_LUI:   begin cls_o.itype = 1'b1; cls_o.ext_op = 1'b1; cls_o.lui = 1'b1; end
            OP_LW:    begin cls_o.load = 1'b1; cls_o.ext_op = 1'b1; end
            OP_SW:    begin cls_o.store = 1'b1; cls_o.ext_op = 1'b1; end
            default:  cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS sequencing FSM; define MULTICYCLE_MEM_WAIT_EN to stall
// IF/MEM on MemReady, otherwise every memory access takes one cycle.
//
//  state | meaning
//  INIT  | post-reset idle, all outputs low
//  IF    | fetch into IR, PC <= PC+4
//  ID    | decode, branch target into ALUOut, jumps finish here
//  EX    | ALU operation / branch resolve / address calc
//  MEM   | data memory read or write
//  WB    | register file write-back
module multi_cycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [2:0]         Branch,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_e      state_q, state_d;
    inst_class_t cls;
    logic        mem_ok;

    inst_class_decoder u_dec (
        .op_code_i (OpCode),
        .funct_i   (Funct),
        .cls_o     (cls)
    );

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = MemReady;
`else
    // Zero-wait memory: MemReady is referenced but has no effect.
    assign mem_ok = MemReady | 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    assign State = STATE_W'(state_q);

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 3'b000;
        PCSource    = PCS_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_MDR;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        ALUSrcA     = ASA_PC;
        ALUSrcB     = ASB_B;
        ALUOp       = ALU_ADD;
        Illegal     = 1'b0;

        case (state_q)
            S_INIT: state_d = S_IF;

            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = ASB_FOUR;
                IRWrite = mem_ok;
                PCWrite = mem_ok;
                state_d = mem_ok ? S_ID : S_IF;
            end

            S_ID: begin
                ALUSrcB = ASB_IMM_SH;
                ExtOp   = 1'b1;
                state_d = S_IF;
                if (cls.illegal) begin
                    Illegal = 1'b1;
                end else if (cls.jump) begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                    if (cls.link) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end else if (cls.jreg) begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_RS;
                    if (cls.link) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RD;
                        MemtoReg = M2R_PC;
                    end
                end else begin
                    state_d = S_EX;
                end
            end

            S_EX: begin
                ALUOp   = cls.alu_op;
                ALUSrcA = ASA_A;
                state_d = S_IF;
                if (cls.branch) begin
                    ALUSrcB     = ASB_B;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                    Branch      = OpCode[2:0];
                end else if (cls.load || cls.store) begin
                    ALUSrcB = ASB_IMM;
                    ExtOp   = 1'b1;
                    state_d = S_MEM;
                end else if (cls.rtype) begin
                    ALUSrcA = cls.shift ? ASA_SHAMT : ASA_A;
                    ALUSrcB = ASB_B;
                    state_d = S_WB;
                end else if (cls.itype) begin
                    ALUSrcB = ASB_IMM;
                    ExtOp   = cls.ext_op;
                    LuiOp   = cls.lui;
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                IorD    = 1'b1;
                state_d = S_IF;
                if (cls.load) begin
                    MemRead = 1'b1;
                    state_d = mem_ok ? S_WB : S_MEM;
                end else if (cls.store) begin
                    MemWrite = 1'b1;
                    state_d  = mem_ok ? S_IF : S_MEM;
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
                if (!cls.load) begin
                    MemtoReg = M2R_ALUOUT;
                    RegDst   = cls.rtype ? RD_RD : RD_RT;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle expected control
// records are queued per instruction and compared on the falling edge.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic       ExtOp, LuiOp, Illegal;
    logic [2:0] Branch, State;
    logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;

    int errors = 0;
    int checks = 0;

    multi_cycle_controller #(.STATE_W(3)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
        .LuiOp(LuiOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       rdy;
        logic       pcw, pcwc;
        logic [2:0] br;
        logic [1:0] pcs;
        logic       iord, mr, mw, irw, rw;
        logic [1:0] rd, m2r, asa, asb;
        logic       ill;
        logic [3:0] alu;
        logic       alu_chk;
        logic       ext, lui, x_chk;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t blank(input logic [2:0] st);
        exp_t x;
        x       = '0;
        x.st    = st;
        x.rdy   = 1'b1;
        return x;
    endfunction

    task automatic compare_rec(input exp_t e);
        logic [23:0] obs, want;
        obs  = {PCWrite, PCWriteCond, Branch, PCSource, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, Illegal};
        want = {e.pcw, e.pcwc, e.br, e.pcs, e.iord, e.mr, e.mw, e.irw,
                e.rw, e.rd, e.m2r, e.asa, e.asb, e.ill};
        chk($sformatf("state(exp s%0d)", e.st), 32'(State), 32'(e.st));
        chk($sformatf("ctl@s%0d", e.st), 32'(obs), 32'(want));
        if (e.alu_chk) chk($sformatf("aluop@s%0d", e.st), 32'(ALUOp), 32'(e.alu));
        if (e.x_chk)   chk($sformatf("ext_lui@s%0d", e.st), 32'({ExtOp, LuiOp}), 32'({e.ext, e.lui}));
    endtask

    // Builds the expected per-cycle sequence for one instruction, then drives
    // it (inputs just after posedge) and compares each cycle at negedge.
    // n_run > 0 stops after that many cycles and drops the rest.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int if_wait, input int mem_wait, input int n_run);
        exp_t lst[$];
        exp_t x, got;
        bit   is_r, jr, jalr, shamt, rfn_ok, br, ld, st, jmp, ity, ill;
        int   n;
        is_r   = (op == 6'h00);
        jr     = is_r && fn == 6'h08;
        jalr   = is_r && fn == 6'h09;
        shamt  = is_r && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
        rfn_ok = fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                            [6'h20:6'h27], 6'h2a, 6'h2b};
        br     = op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
        ld     = (op == 6'h23);
        st     = (op == 6'h2b);
        jmp    = (op == 6'h02 || op == 6'h03);
        ity    = op inside {[6'h08:6'h0d], 6'h0f};
        ill    = is_r ? !rfn_ok : !(br || ld || st || jmp || ity);

`ifdef MULTICYCLE_MEM_WAIT_EN
        for (int w = 0; w < if_wait; w++) begin
            x = blank(3'd1); x.rdy = 1'b0; x.mr = 1'b1; x.asb = 2'b01; x.alu_chk = 1'b1;
            lst.push_back(x);
        end
        x = blank(3'd1);
`else
        // Without the wait feature a low MemReady must be ignored.
        x = blank(3'd1); x.rdy = (if_wait == 0);
`endif
        x.mr = 1'b1; x.irw = 1'b1; x.pcw = 1'b1; x.asb = 2'b01; x.alu_chk = 1'b1;
        lst.push_back(x);

        x = blank(3'd2); x.asb = 2'b11; x.alu_chk = 1'b1;
        if (ill)               x.ill = 1'b1;
        else if (jmp)          begin x.pcw = 1'b1; x.pcs = 2'b10; end
        else if (jr || jalr)   begin x.pcw = 1'b1; x.pcs = 2'b11; end
        if (op == 6'h03)       begin x.rw = 1'b1; x.rd = 2'b10; x.m2r = 2'b10; end
        if (jalr)              begin x.rw = 1'b1; x.rd = 2'b01; x.m2r = 2'b10; end
        lst.push_back(x);

        if (!(ill || jmp || jr || jalr)) begin
            x = blank(3'd3); x.asa = 2'b01;
            if (br) begin
                x.pcwc = 1'b1; x.pcs = 2'b01; x.br = op[2:0];
            end else if (ld || st) begin
                x.asb = 2'b10; x.ext = 1'b1; x.x_chk = 1'b1;
            end else if (is_r) begin
                x.asa = shamt ? 2'b10 : 2'b01;
            end else begin
                x.asb = 2'b10; x.x_chk = 1'b1;
                x.ext = !(op == 6'h0c || op == 6'h0d);
                x.lui = (op == 6'h0f);
            end
            lst.push_back(x);

            if (ld || st) begin
`ifdef MULTICYCLE_MEM_WAIT_EN
                for (int w = 0; w < mem_wait; w++) begin
                    x = blank(3'd4); x.rdy = 1'b0; x.iord = 1'b1; x.mr = ld; x.mw = st;
                    lst.push_back(x);
                end
                x = blank(3'd4);
`else
                x = blank(3'd4); x.rdy = (mem_wait == 0);
`endif
                x.iord = 1'b1; x.mr = ld; x.mw = st;
                lst.push_back(x);
            end

            if (!br && !st) begin
                x = blank(3'd5); x.rw = 1'b1;
                if (is_r)     begin x.rd = 2'b01; x.m2r = 2'b01; end
                else if (ity) x.m2r = 2'b01;
                lst.push_back(x);
            end
        end

        foreach (lst[i]) sb.push_back(lst[i]);
        n = (n_run > 0 && n_run < lst.size()) ? n_run : lst.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            OpCode = op; Funct = fn; MemReady = lst[k].rdy;
            @(negedge clk);
            got = sb.pop_front();
            compare_rec(got);
        end
        for (int k = n; k < lst.size(); k++) x = sb.pop_front();
    endtask

    task automatic release_and_check_init();
        exp_t x;
        @(posedge clk); #1;
        reset = 1'b1;
        x = blank(3'd0); x.alu_chk = 1'b1; x.x_chk = 1'b1;
        sb.push_back(x);
        @(negedge clk);
        compare_rec(sb.pop_front());
    endtask

    typedef struct { logic [5:0] op; logic [5:0] fn; } instr_t;
    instr_t prog[$];

    initial begin
        reset = 1'b0; OpCode = 6'h00; Funct = 6'h00; MemReady = 1'b1;
        #12;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_strobes", 32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Illegal}), 32'd0);
        release_and_check_init();

        prog = '{'{6'h00, 6'h20}, '{6'h23, 6'h00}, '{6'h04, 6'h00}, '{6'h05, 6'h00},
                 '{6'h01, 6'h00}, '{6'h07, 6'h00}, '{6'h03, 6'h00}, '{6'h02, 6'h00},
                 '{6'h00, 6'h08}, '{6'h00, 6'h09}, '{6'h00, 6'h00}, '{6'h00, 6'h2a},
                 '{6'h0c, 6'h00}, '{6'h0f, 6'h00}, '{6'h08, 6'h00}, '{6'h0b, 6'h00},
                 '{6'h2b, 6'h00}, '{6'h3f, 6'h00}, '{6'h00, 6'h3f}, '{6'h00, 6'h00}};
        foreach (prog[i]) run_instr(prog[i].op, prog[i].fn, 0, 0, 0);

        // Memory wait states on lw (fetch held 3 cycles, MEM held 2).
        run_instr(6'h23, 6'h00, 2, 1, 0);
        run_instr(6'h2b, 6'h00, 0, 1, 0);

        // sw abandoned by an asynchronous reset in the middle of MEM.
        run_instr(6'h2b, 6'h00, 0, 0, 3);
        @(posedge clk); #1;
        MemReady = 1'b1;
        #2;
        chk("sw_mem_state", 32'(State), 32'd4);
        chk("sw_mem_write", 32'(MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_strobes", 32'({MemWrite, IorD, MemRead, PCWrite, RegWrite}), 32'd0);
        release_and_check_init();
        run_instr(6'h00, 6'h22, 0, 0, 0);
        run_instr(6'h23, 6'h00, 0, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
